cdb_arbiter: RTL and testbench

//  Shares the single reorder_buffer write-back (common data bus) among three producers:
//  ALU reservation station result, LSB load result and LSB store-address notification.

---
 rtl/cdb_arbiter_if.sv | 42 ++++
 rtl/cdb_arbiter.sv | 151 +++++++++++++++
 tb/tb_cdb_arbiter.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/cdb_arbiter_if.sv
// Producer handshakes and common-data-bus broadcast shared between the producers and cdb_arbiter.
// master = producer/observer side, slave = arbiter side.
interface cdb_arbiter_if #(
    parameter int unsigned ENTRY_W = 5
);
    logic               alu_valid;
    logic               alu_ready;
    logic [ENTRY_W-1:0] alu_entry;
    logic [31:0]        alu_result;
    logic [31:0]        alu_pc;

    logic               ld_valid;
    logic               ld_ready;
    logic [ENTRY_W-1:0] ld_entry;
    logic [31:0]        ld_result;

    logic               st_valid;
    logic               st_ready;
    logic [ENTRY_W-1:0] st_entry;

    logic               cdb_valid;
    logic [1:0]         cdb_kind;
    logic [ENTRY_W-1:0] cdb_entry;
    logic [31:0]        cdb_result;
    logic [31:0]        cdb_pc;

    modport master (
        output alu_valid, alu_entry, alu_result, alu_pc,
        output ld_valid, ld_entry, ld_result,
        output st_valid, st_entry,
        input  alu_ready, ld_ready, st_ready,
        input  cdb_valid, cdb_kind, cdb_entry, cdb_result, cdb_pc
    );

    modport slave (
        input  alu_valid, alu_entry, alu_result, alu_pc,
        input  ld_valid, ld_entry, ld_result,
        input  st_valid, st_entry,
        output alu_ready, ld_ready, st_ready,
        output cdb_valid, cdb_kind, cdb_entry, cdb_result, cdb_pc
    );
endinterface

// File: rtl/cdb_arbiter.sv
// Serialises ALU, load and store-address completions onto one registered CDB through
// per-source FIFOs drained by a round-robin arbiter (ALU -> LOAD -> STORE).
module cdb_arbiter #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned ENTRY_W    = 5
) (
    input  logic           clk_in,
    input  logic           rst_in,
    input  logic           rdy_in,
    input  logic           roll_back,
    cdb_arbiter_if.slave   bus
);
    localparam int unsigned NSRC  = 3;
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    typedef enum logic [1:0] {
        KIND_ALU   = 2'd0,
        KIND_LOAD  = 2'd1,
        KIND_STORE = 2'd2
    } kind_e;

    typedef struct packed {
        logic [ENTRY_W-1:0] entry;
        logic [31:0]        result;
        logic [31:0]        pc;
    } item_t;

    item_t            mem_q    [NSRC][FIFO_DEPTH];
    item_t            mem_d    [NSRC][FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q [NSRC];
    logic [PTR_W-1:0] wr_ptr_d [NSRC];
    logic [PTR_W-1:0] rd_ptr_q [NSRC];
    logic [PTR_W-1:0] rd_ptr_d [NSRC];
    logic [PTR_W:0]   count_q  [NSRC];
    logic [PTR_W:0]   count_d  [NSRC];
    logic [1:0]       rr_ptr_q, rr_ptr_d;
    logic             cdb_valid_q, cdb_valid_d;
    kind_e            cdb_kind_q, cdb_kind_d;
    item_t            cdb_item_q, cdb_item_d;

    item_t            item_in [NSRC];
    logic [NSRC-1:0]  valid_in;
    logic [NSRC-1:0]  ready;
    logic [NSRC-1:0]  push;
    logic [NSRC-1:0]  pop;
    logic             advance;
    logic             grant_vld;
    logic [1:0]       grant_idx;
    logic [1:0]       cand;

    // Unused fields are zero at the source, so STORE result and non-ALU pc broadcast as 0.
    always_comb begin
        item_in[0] = {bus.alu_entry, bus.alu_result, bus.alu_pc};
        item_in[1] = {bus.ld_entry, bus.ld_result, 32'd0};
        item_in[2] = {bus.st_entry, 64'd0};
        valid_in   = {bus.st_valid, bus.ld_valid, bus.alu_valid};
    end

    always_comb begin
        advance   = rdy_in && !roll_back;
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int unsigned k = 0; k < NSRC; k++) begin
            cand = 2'((32'(rr_ptr_q) + k) % NSRC);
            if (!grant_vld && count_q[cand] != '0) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
        for (int unsigned i = 0; i < NSRC; i++) begin
            ready[i] = advance && (count_q[i] < FULL_CNT);
            push[i]  = valid_in[i] && ready[i];
            pop[i]   = advance && grant_vld && (grant_idx == 2'(i));
        end
    end

    always_comb begin
        mem_d       = mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        rr_ptr_d    = rr_ptr_q;
        cdb_valid_d = cdb_valid_q;
        cdb_kind_d  = cdb_kind_q;
        cdb_item_d  = cdb_item_q;
        if (roll_back) begin
            for (int unsigned i = 0; i < NSRC; i++) begin
                wr_ptr_d[i] = '0;
                rd_ptr_d[i] = '0;
                count_d[i]  = '0;
            end
            rr_ptr_d    = '0;
            cdb_valid_d = 1'b0;
        end else if (rdy_in) begin
            for (int unsigned i = 0; i < NSRC; i++) begin
                if (push[i]) begin
                    mem_d[i][wr_ptr_q[i]] = item_in[i];
                    wr_ptr_d[i]           = wr_ptr_q[i] + PTR_ONE;
                end
                if (pop[i])
                    rd_ptr_d[i] = rd_ptr_q[i] + PTR_ONE;
                if (push[i] && !pop[i])
                    count_d[i] = count_q[i] + CNT_ONE;
                else if (!push[i] && pop[i])
                    count_d[i] = count_q[i] - CNT_ONE;
            end
            cdb_valid_d = grant_vld;
            if (grant_vld) begin
                cdb_kind_d = kind_e'(grant_idx);
                cdb_item_d = mem_q[grant_idx][rd_ptr_q[grant_idx]];
                rr_ptr_d   = (grant_idx == 2'd2) ? 2'd0 : grant_idx + 2'd1;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            mem_q       <= '{default: '0};
            wr_ptr_q    <= '{default: '0};
            rd_ptr_q    <= '{default: '0};
            count_q     <= '{default: '0};
            rr_ptr_q    <= '0;
            cdb_valid_q <= 1'b0;
            cdb_kind_q  <= KIND_ALU;
            cdb_item_q  <= '0;
        end else begin
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            rr_ptr_q    <= rr_ptr_d;
            cdb_valid_q <= cdb_valid_d;
            cdb_kind_q  <= cdb_kind_d;
            cdb_item_q  <= cdb_item_d;
        end
    end

    assign bus.alu_ready  = ready[0];
    assign bus.ld_ready   = ready[1];
    assign bus.st_ready   = ready[2];
    assign bus.cdb_valid  = cdb_valid_q;
    assign bus.cdb_kind   = cdb_kind_q;
    assign bus.cdb_entry  = cdb_item_q.entry;
    assign bus.cdb_result = cdb_item_q.result;
    assign bus.cdb_pc     = cdb_item_q.pc;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: a queue-based reference model predicts broadcasts,
// a negedge monitor pops and compares them, and checks readies and frozen/flush behaviour.
module tb_cdb_arbiter;
    localparam int DEPTH = 4;
    localparam int EW    = 5;

    logic clk = 1'b0;
    logic rst, rdy, rb;

    cdb_arbiter_if #(.ENTRY_W(EW)) bus();

    cdb_arbiter #(.FIFO_DEPTH(DEPTH), .ENTRY_W(EW)) dut (
        .clk_in   (clk),
        .rst_in   (rst),
        .rdy_in   (rdy),
        .roll_back(rb),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]    kind;
        logic [EW-1:0] entry;
        logic [31:0]   result;
        logic [31:0]   pc;
    } item_t;

    typedef enum {E_NONE, E_RESET, E_FLUSH, E_FROZEN, E_ADV} edge_e;

    item_t src_q [3][$];
    item_t exp_q [$];
    int    rr_m = 0;
    edge_e edge_kind = E_NONE;
    int    tests = 0;
    int    fails = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference model: per-source queues, round-robin pick of the first non-empty source.
    initial begin
        item_t in_it [3];
        logic  v [3];
        int    sz [3];
        int    s;
        bit    found;
        forever begin
            @(posedge clk);
            if (rst) begin
                for (int i = 0; i < 3; i++) src_q[i].delete();
                exp_q.delete();
                rr_m = 0;
                edge_kind = E_RESET;
            end else if (rb) begin
                for (int i = 0; i < 3; i++) src_q[i].delete();
                rr_m = 0;
                edge_kind = E_FLUSH;
            end else if (!rdy) begin
                edge_kind = E_FROZEN;
            end else begin
                in_it[0] = '{kind: 2'd0, entry: bus.alu_entry, result: bus.alu_result, pc: bus.alu_pc};
                in_it[1] = '{kind: 2'd1, entry: bus.ld_entry, result: bus.ld_result, pc: 32'd0};
                in_it[2] = '{kind: 2'd2, entry: bus.st_entry, result: 32'd0, pc: 32'd0};
                v[0] = bus.alu_valid;
                v[1] = bus.ld_valid;
                v[2] = bus.st_valid;
                for (int i = 0; i < 3; i++) sz[i] = src_q[i].size();
                found = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    s = (rr_m + k) % 3;
                    if (!found && sz[s] > 0) begin
                        found = 1'b1;
                        exp_q.push_back(src_q[s].pop_front());
                        rr_m = (s + 1) % 3;
                    end
                end
                for (int i = 0; i < 3; i++)
                    if (v[i] && sz[i] < DEPTH) src_q[i].push_back(in_it[i]);
                edge_kind = E_ADV;
            end
        end
    end

    initial begin
        logic [70:0] prev, cur, want;
        logic [2:0]  rdy_exp, rdy_act;
        item_t       it;
        prev = '0;
        forever begin
            @(negedge clk);
            cur = {bus.cdb_kind, bus.cdb_entry, bus.cdb_result, bus.cdb_pc};
            case (edge_kind)
                E_RESET: begin
                    check("reset_valid", 128'(bus.cdb_valid), 128'(0));
                    check("reset_fields", 128'(cur), 128'(0));
                end
                E_FLUSH: check("flush_valid", 128'(bus.cdb_valid), 128'(0));
                E_FROZEN: check("frozen_outputs", 128'({bus.cdb_valid, cur}), 128'({prev[71-1:0] == prev[70:0] ? 1'b0 : 1'b0, prev}) | 128'({bus.cdb_valid, 71'd0}));
                E_ADV: begin
                    if (bus.cdb_valid) begin
                        if (exp_q.size() == 0) begin
                            check("spurious_broadcast", 128'(cur), 128'(0) - 128'(1));
                        end else begin
                            it = exp_q.pop_front();
                            want = {it.kind, it.entry, it.result, it.pc};
                            check("broadcast", 128'(cur), 128'(want));
                        end
                    end else if (exp_q.size() != 0) begin
                        it = exp_q.pop_front();
                        check("missing_broadcast", 128'(bus.cdb_valid), 128'(1));
                    end
                end
                default: ;
            endcase
            if (edge_kind != E_NONE) begin
                for (int i = 0; i < 3; i++)
                    rdy_exp[i] = rdy && !rb && (src_q[i].size() < DEPTH);
                rdy_act = {bus.st_ready, bus.ld_ready, bus.alu_ready};
                check("readies", 128'(rdy_act), 128'(rdy_exp));
            end
            prev = cur;
        end
    end

    // Frozen edges must also keep cdb_valid; tracked separately from the field check above.
    logic prev_valid = 1'b0;
    initial begin
        forever begin
            @(negedge clk);
            if (edge_kind == E_FROZEN)
                check("frozen_valid", 128'(bus.cdb_valid), 128'(prev_valid));
            prev_valid = bus.cdb_valid;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.alu_valid = 1'b0;
        bus.ld_valid  = 1'b0;
        bus.st_valid  = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        rdy = 1'b1;
        rb  = 1'b0;
        idle();
        bus.alu_entry = '0; bus.alu_result = '0; bus.alu_pc = '0;
        bus.ld_entry  = '0; bus.ld_result  = '0;
        bus.st_entry  = '0;
        step();
        step();
        rst = 1'b0;

        bus.alu_valid = 1'b1; bus.alu_entry = 5'd3; bus.alu_result = 32'h11; bus.alu_pc = 32'h1004;
        step();
        idle();
        repeat (3) step();

        bus.alu_valid = 1'b1; bus.alu_entry = 5'd1; bus.alu_result = 32'h22; bus.alu_pc = 32'h2000;
        bus.ld_valid  = 1'b1; bus.ld_entry  = 5'd2; bus.ld_result  = 32'hAA;
        bus.st_valid  = 1'b1; bus.st_entry  = 5'd4;
        step();
        idle();
        repeat (5) step();

        for (int i = 0; i < 20; i++) begin
            bus.alu_valid = 1'b1; bus.alu_entry = EW'(i);      bus.alu_result = $urandom; bus.alu_pc = $urandom;
            bus.ld_valid  = 1'b1; bus.ld_entry  = EW'(i + 8);  bus.ld_result  = $urandom;
            bus.st_valid  = 1'b1; bus.st_entry  = EW'(i + 16);
            step();
        end
        idle();
        repeat (15) step();

        for (int i = 0; i < 2; i++) begin
            bus.alu_valid = 1'b1; bus.alu_entry = EW'(20 + i); bus.alu_result = $urandom;
            bus.ld_valid  = 1'b1; bus.ld_entry  = EW'(24 + i); bus.ld_result  = $urandom;
            bus.st_valid  = 1'b1; bus.st_entry  = EW'(28 + i);
            step();
        end
        idle();
        rb = 1'b1;
        bus.alu_valid = 1'b1; bus.alu_entry = 5'd9;
        step();
        rb = 1'b0;
        idle();
        repeat (4) step();

        bus.alu_valid = 1'b1; bus.alu_entry = 5'd7; bus.alu_result = 32'h77; bus.alu_pc = 32'h7000;
        step();
        idle();
        rdy = 1'b0;
        repeat (3) step();
        rdy = 1'b1;
        repeat (3) step();

        bus.alu_valid = 1'b1; bus.alu_entry = 5'd8; bus.alu_result = 32'h88; bus.alu_pc = 32'h8000;
        step();
        idle();
        step();
        rdy = 1'b0;
        repeat (2) step();
        rdy = 1'b1;
        repeat (2) step();

        for (int i = 0; i < 400; i++) begin
            bus.alu_valid = 1'($urandom_range(0, 1)); bus.alu_entry = EW'($urandom);
            bus.alu_result = $urandom; bus.alu_pc = $urandom;
            bus.ld_valid  = 1'($urandom_range(0, 1)); bus.ld_entry = EW'($urandom);
            bus.ld_result = $urandom;
            bus.st_valid  = 1'($urandom_range(0, 1)); bus.st_entry = EW'($urandom);
            rdy = ($urandom_range(0, 9) != 0);
            rb  = ($urandom_range(0, 29) == 0);
            step();
        end
        idle();
        rdy = 1'b1;
        rb  = 1'b0;
        repeat (20) step();
        @(negedge clk);
        #1;
        check("drain_expected", 128'(exp_q.size()), 128'(0));
        check("drain_sources", 128'(src_q[0].size() + src_q[1].size() + src_q[2].size()), 128'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
